// File: rtl/alu_pkg.sv
// Shared definitions for the bus ALU: opcode values, flag bit positions and
// the multiplier sequencer state type.
package alu_pkg;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_ADC  = 2;
    localparam int unsigned OP_SBC  = 3;
    localparam int unsigned OP_AND  = 4;
    localparam int unsigned OP_OR   = 5;
    localparam int unsigned OP_XOR  = 6;
    localparam int unsigned OP_NOT  = 7;
    localparam int unsigned OP_SHL  = 8;
    localparam int unsigned OP_SHR  = 9;
    localparam int unsigned OP_ROL  = 10;
    localparam int unsigned OP_CMP  = 11;
    localparam int unsigned OP_MUL  = 12;

    // flags port is packed {C,Z,N,V}
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
// state | meaning
// IDLE  | waiting for start; operands captured on start
// MUL   | one shift-add step per cycle, count runs WIDTH..1
// DONE  | product final, valid=1 for exactly this cycle
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   product,
    output logic                 valid
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t           r_state;
    mul_state_t           w_state_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_count;
    logic                 w_tc;

    // count is about to reach zero on this edge: last step
    assign w_tc = (r_count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = MUL;
            MUL:     if (w_tc)  w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (r_state == IDLE && start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH);
        end else if (r_state == MUL) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
        end
    end

    assign busy    = (r_state != IDLE);
    assign valid   = (r_state == DONE);
    assign product = r_acc;

endmodule
`endif

// File: rtl/alu_seq.sv
// Bus ALU with operand registers A/B and latched {C,Z,N,V} flags.
// Define ALU_MUL_EN to add the sequential multiplier (op MUL, busy/done).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  bus_in,
    output logic [WIDTH-1:0]  bus_out,
    input  logic              rega_write_enable,
    input  logic              regb_write_enable,
    input  logic              rega_enable,
    input  logic              regb_enable,
    input  logic              alu_enable,
    input  logic [OPW-1:0]    op,
    input  logic              flags_write_enable,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [3:0]        flags
);

    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [3:0]          r_flags;

    logic                w_busy;
    logic                w_done;
    logic [2*WIDTH-1:0]  w_product;

    logic [OPW-1:0]      w_op;
    logic [WIDTH-1:0]    w_opb;
    logic                w_cin;
    logic                w_arith;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_res;
    logic                w_c;
    logic                w_v;
    logic [WIDTH-1:0]    w_alu_bus;
    logic [3:0]          w_flags_next;

`ifdef ALU_MUL_EN
    logic w_mul_start;

    assign w_mul_start = start && (op == OPW'(OP_MUL));

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (r_a),
        .b       (r_b),
        .busy    (w_busy),
        .product (w_product),
        .valid   (w_done)
    );
`else
    logic w_unused_start;

    assign w_unused_start = start;
    assign w_busy         = 1'b0;
    assign w_done         = 1'b0;
    assign w_product      = '0;
`endif

    // while the multiplier runs the ALU output is forced to A+B
    assign w_op = w_busy ? OPW'(OP_ADD) : op;

    // add/sub family shares one adder: A + (B or ~B) + cin
    always_comb begin
        w_opb   = r_b;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (w_op)
            OPW'(OP_ADD): w_arith = 1'b1;
            OPW'(OP_SUB),
            OPW'(OP_CMP): begin
                w_opb   = ~r_b;
                w_cin   = 1'b1;
                w_arith = 1'b1;
            end
            OPW'(OP_ADC): begin
                w_cin   = r_flags[FLAG_C];
                w_arith = 1'b1;
            end
            OPW'(OP_SBC): begin
                w_opb   = ~r_b;
                w_cin   = r_flags[FLAG_C];
                w_arith = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, r_a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_res = r_a;
        w_c   = 1'b0;
        w_v   = 1'b0;
        if (w_arith) begin
            w_res = w_sum[M:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_a[M] == w_opb[M]) && (w_sum[M] != r_a[M]);
        end else begin
            case (w_op)
                OPW'(OP_AND): w_res = r_a & r_b;
                OPW'(OP_OR):  w_res = r_a | r_b;
                OPW'(OP_XOR): w_res = r_a ^ r_b;
                OPW'(OP_NOT): w_res = ~r_a;
                OPW'(OP_SHL): begin
                    w_res = {r_a[M-1:0], 1'b0};
                    w_c   = r_a[M];
                end
                OPW'(OP_SHR): begin
                    w_res = {1'b0, r_a[M:1]};
                    w_c   = r_a[0];
                end
                OPW'(OP_ROL): begin
                    w_res = {r_a[M-1:0], r_flags[FLAG_C]};
                    w_c   = r_a[M];
                end
                default: w_res = r_a;
            endcase
        end
    end

    // CMP keeps A on the bus; its subtraction only reaches the flags
    assign w_alu_bus = (w_op == OPW'(OP_CMP)) ? r_a : w_res;

    always_comb begin
        w_flags_next         = 4'b0000;
        w_flags_next[FLAG_C] = w_c;
        w_flags_next[FLAG_Z] = (w_res == '0);
        w_flags_next[FLAG_N] = w_res[M];
        w_flags_next[FLAG_V] = w_v;
    end

    always_comb begin
        if (alu_enable) begin
            bus_out = w_alu_bus;
        end else if (rega_enable) begin
            bus_out = r_a;
        end else if (regb_enable) begin
            bus_out = r_b;
        end else begin
            bus_out = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_flags <= 4'b0000;
        end else if (w_done) begin
            r_a             <= w_product[M:0];
            r_b             <= w_product[2*WIDTH-1:WIDTH];
            r_flags         <= 4'b0000;
            r_flags[FLAG_C] <= (w_product[2*WIDTH-1:WIDTH] != '0);
            r_flags[FLAG_Z] <= (w_product == '0);
        end else if (!w_busy) begin
            if (rega_write_enable) begin
                r_a <= bus_in;
            end else if (regb_write_enable) begin
                r_b <= bus_in;
            end
            if (flags_write_enable) begin
                r_flags <= w_flags_next;
            end
        end
    end

    assign busy  = w_busy;
    assign done  = w_done;
    assign flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed table, random ops
// against an arithmetic reference model, and multiplier sequences.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       rega_write_enable;
    logic       regb_write_enable;
    logic       rega_enable;
    logic       regb_enable;
    logic       alu_enable;
    logic [3:0] op;
    logic       flags_write_enable;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] flags;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(8), .OPW(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus_in             (bus_in),
        .bus_out            (bus_out),
        .rega_write_enable  (rega_write_enable),
        .regb_write_enable  (regb_write_enable),
        .rega_enable        (rega_enable),
        .regb_enable        (regb_enable),
        .alu_enable         (alu_enable),
        .op                 (op),
        .flags_write_enable (flags_write_enable),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .flags              (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] exp_bus;
        logic [3:0] exp_flags;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_a(input logic [7:0] v);
        bus_in = v;
        rega_write_enable = 1'b1;
        step();
        rega_write_enable = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] v);
        bus_in = v;
        regb_write_enable = 1'b1;
        step();
        regb_write_enable = 1'b0;
    endtask

    task automatic read_a(output logic [7:0] v);
        alu_enable = 1'b0;
        rega_enable = 1'b1;
        #1 v = bus_out;
        rega_enable = 1'b0;
    endtask

    task automatic read_b(output logic [7:0] v);
        alu_enable = 1'b0;
        regb_enable = 1'b1;
        #1 v = bus_out;
        regb_enable = 1'b0;
    endtask

    // carry is set up by latching the flags of a left shift
    task automatic set_c(input logic c);
        load_a(c ? 8'h80 : 8'h00);
        op = 4'd8;
        flags_write_enable = 1'b1;
        step();
        flags_write_enable = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [3:0] o, input logic [7:0] a,
                           input logic [7:0] b, input logic c,
                           input logic [7:0] eb, input logic [3:0] ef);
        set_c(c);
        load_a(a);
        load_b(b);
        op = o;
        alu_enable = 1'b1;
        #1 chk({name, " bus"}, {24'd0, bus_out}, {24'd0, eb});
        flags_write_enable = 1'b1;
        step();
        flags_write_enable = 1'b0;
        alu_enable = 1'b0;
        chk({name, " flags"}, {28'd0, flags}, {28'd0, ef});
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic bit ovf(input int s);
        return (s > 127) || (s < -128);
    endfunction

    // reference: returns {bus, C, Z, N, V}
    function automatic logic [11:0] ref_alu(input int o, input int a, input int b, input int c);
        int t;
        int res;
        int cy;
        int v;
        int bus;
        t = 0; res = a; cy = 0; v = 0;
        case (o)
            0:  begin t = a + b;     res = t % 256; cy = int'(t >= 256); v = int'(ovf(sgn(a) + sgn(b))); end
            1, 11: begin t = a - b;  res = (t + 256) % 256; cy = int'(t >= 0); v = int'(ovf(sgn(a) - sgn(b))); end
            2:  begin t = a + b + c; res = t % 256; cy = int'(t >= 256); v = int'(ovf(sgn(a) + sgn(b) + c)); end
            3:  begin t = a - b - (1 - c); res = (t + 512) % 256; cy = int'(t >= 0);
                      v = int'(ovf(sgn(a) - sgn(b) - (1 - c))); end
            4:  res = a & b;
            5:  res = a | b;
            6:  res = a ^ b;
            7:  res = 255 - a;
            8:  begin res = (a * 2) % 256; cy = int'(a >= 128); end
            9:  begin res = a / 2; cy = a % 2; end
            10: begin res = (a * 2) % 256 + c; cy = int'(a >= 128); end
            default: res = a;
        endcase
        bus = (o == 11) ? a : res;
        return {bus[7:0], cy[0], res == 0, res >= 128, v[0]};
    endfunction

    vec_t vtab[16];
    int   nv;

    initial begin
        logic [7:0]  rv;
        logic [11:0] exp;
        int          o;
        int          a;
        int          b;
        int          c;
        int          done_cycle;
        int          busy_cycles;
        int          done_seen;

        rst_n = 1'b0;
        bus_in = 8'h00;
        rega_write_enable = 1'b0;
        regb_write_enable = 1'b0;
        rega_enable = 1'b0;
        regb_enable = 1'b0;
        alu_enable = 1'b0;
        op = 4'd0;
        flags_write_enable = 1'b0;
        start = 1'b0;

        // op, a, b, c, bus, {C,Z,N,V}
        vtab[0]  = '{4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011};
        vtab[1]  = '{4'd1,  8'h05, 8'h05, 1'b0, 8'h00, 4'b1100};
        vtab[2]  = '{4'd1,  8'h03, 8'h05, 1'b0, 8'hFE, 4'b0010};
        vtab[3]  = '{4'd2,  8'h10, 8'h20, 1'b1, 8'h31, 4'b0000};
        vtab[4]  = '{4'd11, 8'h10, 8'h20, 1'b0, 8'h10, 4'b0010};
        vtab[5]  = '{4'd8,  8'h80, 8'h00, 1'b0, 8'h00, 4'b1100};
        vtab[6]  = '{4'd3,  8'h10, 8'h05, 1'b0, 8'h0A, 4'b1000};
        vtab[7]  = '{4'd10, 8'h81, 8'h00, 1'b1, 8'h03, 4'b1000};
        vtab[8]  = '{4'd9,  8'h01, 8'h00, 1'b0, 8'h00, 4'b1100};
        vtab[9]  = '{4'd4,  8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000};
        vtab[10] = '{4'd5,  8'hF0, 8'h0F, 1'b0, 8'hFF, 4'b0010};
        vtab[11] = '{4'd6,  8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0100};
        vtab[12] = '{4'd7,  8'h0F, 8'h00, 1'b0, 8'hF0, 4'b0010};
        vtab[13] = '{4'd13, 8'h5A, 8'h00, 1'b0, 8'h5A, 4'b0000};
        vtab[14] = '{4'd1,  8'h80, 8'h01, 1'b0, 8'h7F, 4'b1001};
        vtab[15] = '{4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100};
        nv = 16;

        #12 rst_n = 1'b1;
        step();

        read_a(rv);  chk("reset A", {24'd0, rv}, 32'h0);
        read_b(rv);  chk("reset B", {24'd0, rv}, 32'h0);
        chk("reset flags", {28'd0, flags}, 32'h0);
        chk("reset busy", {31'd0, busy}, 32'h0);
        chk("reset done", {31'd0, done}, 32'h0);
        #1 chk("idle bus", {24'd0, bus_out}, 32'hFF);

        for (int i = 0; i < nv; i++) begin
            run_vec($sformatf("vec%0d", i), vtab[i].op, vtab[i].a, vtab[i].b, vtab[i].c,
                    vtab[i].exp_bus, vtab[i].exp_flags);
        end

        for (int i = 0; i < 150; i++) begin
            o = int'($urandom_range(0, 14));
            if (o >= 12) o++;
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            c = int'($urandom_range(0, 1));
            exp = ref_alu(o, a, b, c);
            run_vec($sformatf("rnd%0d op%0d", i, o), o[3:0], a[7:0], b[7:0], c[0],
                    exp[11:4], exp[3:0]);
        end

        // write priority and bus priority
        load_a(8'h11);
        load_b(8'h22);
        bus_in = 8'hAA;
        rega_write_enable = 1'b1;
        regb_write_enable = 1'b1;
        step();
        rega_write_enable = 1'b0;
        regb_write_enable = 1'b0;
        read_a(rv);  chk("dual we A", {24'd0, rv}, 32'hAA);
        read_b(rv);  chk("dual we B", {24'd0, rv}, 32'h22);
        op = 4'd0;
        alu_enable = 1'b1; rega_enable = 1'b1; regb_enable = 1'b1;
        #1 chk("bus prio alu", {24'd0, bus_out}, 32'hCC);
        alu_enable = 1'b0;
        #1 chk("bus prio A", {24'd0, bus_out}, 32'hAA);
        rega_enable = 1'b0; regb_enable = 1'b0;
        #1 chk("no enable bus", {24'd0, bus_out}, 32'hFF);

`ifdef ALU_MUL_EN
        // 0x0F * 0x11 = 0x00FF
        load_a(8'h0F);
        load_b(8'h11);
        op = 4'd12;
        start = 1'b1;
        step();
        start = 1'b0;
        done_cycle = 0; busy_cycles = 0; done_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) busy_cycles++;
            if (done) begin
                done_seen++;
                if (done_cycle == 0) done_cycle = k;
            end
            if (k == 2) begin
                alu_enable = 1'b1;
                #1 chk("busy alu add", {24'd0, bus_out}, 32'h20);
                alu_enable = 1'b0;
            end
            if (k == 3) begin
                bus_in = 8'h55;
                rega_write_enable = 1'b1;
                flags_write_enable = 1'b1;
            end
            step();
            rega_write_enable = 1'b0;
            flags_write_enable = 1'b0;
        end
        chk("mul busy cycles", busy_cycles, 9);
        chk("mul done cycle", done_cycle, 9);
        chk("mul done pulses", done_seen, 1);
        read_a(rv);  chk("mul1 A", {24'd0, rv}, 32'hFF);
        read_b(rv);  chk("mul1 B", {24'd0, rv}, 32'h00);
        chk("mul1 flags", {28'd0, flags}, 32'h0);

        // 0xFF * 0xFF = 0xFE01
        load_a(8'hFF);
        load_b(8'hFF);
        op = 4'd12;
        start = 1'b1;
        step();
        start = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20 && (busy || done); k++) begin
            if (done) done_seen++;
            step();
        end
        chk("mul2 idle", {31'd0, busy}, 32'h0);
        chk("mul2 done pulses", done_seen, 1);
        read_a(rv);  chk("mul2 A", {24'd0, rv}, 32'h01);
        read_b(rv);  chk("mul2 B", {24'd0, rv}, 32'hFE);
        chk("mul2 flags", {28'd0, flags}, 32'h8);

        // start with a non-MUL op is ignored
        op = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start non-mul busy", {31'd0, busy}, 32'h0);

        // abort in the 4th multiply cycle
        load_a(8'h33);
        load_b(8'h44);
        op = 4'd12;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("abort pre busy", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        #2;
        chk("abort busy", {31'd0, busy}, 32'h0);
        read_a(rv);  chk("abort A", {24'd0, rv}, 32'h0);
        read_b(rv);  chk("abort B", {24'd0, rv}, 32'h0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) done_seen++;
            step();
        end
        chk("abort no done", done_seen, 0);
`else
        // without the multiplier: start ignored, op 12 passes A
        load_a(8'h3C);
        load_b(8'h02);
        op = 4'd12;
        start = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (busy || done) busy_cycles++;
        end
        start = 1'b0;
        chk("no-mul busy/done", busy_cycles, 0);
        alu_enable = 1'b1;
        #1 chk("no-mul op12 pass", {24'd0, bus_out}, 32'h3C);
        alu_enable = 1'b0;
        read_b(rv);  chk("no-mul B kept", {24'd0, rv}, 32'h02);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised next-generation ALU for the bus-based CPU datapath.
- Holds operand registers A and B, loaded from the shared bus.
- Combinational ops: add/sub with and without carry-in, logic, shift, compare. Result drives the bus on request.
- Latched flags register (C, Z, N, V) for conditional jumps.
- Optional multi-cycle shift-add multiplier with start/busy/done handshake.

Parameters:
- WIDTH, 8: data/bus width in bits (>=2).
- OPW, 4: opcode width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_in  in  WIDTH  data bus input.
- bus_out  out  WIDTH  data bus drive.
- rega_write_enable  in  1  load A from bus_in.
- regb_write_enable  in  1  load B from bus_in.
- rega_enable  in  1  drive A onto bus_out.
- regb_enable  in  1  drive B onto bus_out.
- alu_enable  in  1  drive result onto bus_out.
- op  in  OPW  operation select.
- flags_write_enable  in  1  latch flags from current result.
- start  in  1  begin multiply (op must equal MUL).
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when product is written.
- flags  out  4  {C,Z,N,V}.

Behaviour:
- Reset (async, rst_n=0): A=0, B=0, flags=0, busy=0, done=0, FSM=IDLE, multiplier counter=0.
- Op codes: 0 ADD A+B; 1 SUB A-B (A+~B+1); 2 ADC A+B+C; 3 SBC A+~B+C; 4 AND; 5 OR; 6 XOR; 7 NOT A; 8 SHL A (C=A[MSB]); 9 SHR A logical (C=A[0]); 10 ROL A through C; 11 CMP (SUB result for flags only, bus shows A); 12 MUL; 13-15 pass A.
- Result arithmetic is mod 2^WIDTH. C is the carry-out; for SUB, C=1 means no borrow.
- Z = result==0. N = result[MSB]. V = signed overflow (add/sub variants only; 0 for the others).
- bus_out is combinational, priority alu_enable > rega_enable > regb_enable. With none asserted it is all ones.
- Writes at posedge: rega_write_enable has priority over regb_write_enable. One register loads per cycle.
- Flags load at posedge when flags_write_enable=1 and FSM=IDLE.
- FSM states IDLE, MUL, DONE:
  - IDLE: start=1 and op=MUL go to MUL. Copy A to multiplicand, B to multiplier, clear accumulator, count=WIDTH.
  - MUL: one shift-add step per cycle; count decrements. Leave when count hits 0 after exactly WIDTH cycles.
  - DONE: A<=product[WIDTH-1:0], B<=product[2W-1:W], done=1 for this cycle. Flags update: Z = full product==0, C = high half!=0, N=V=0. Return to IDLE.
- busy=1 in MUL and DONE.
- While busy: register/flag write enables and start are ignored. Bus drive still works; alu_enable shows ADD of current A,B.
- start with op!=MUL: ignored.
- Latency: start edge to done = WIDTH+1 cycles.
- rst_n low mid-multiply: abort, all state reset, no done pulse.

Optional Feature:
- ALU_MUL_EN defined: MUL op, FSM, busy/done as above.
- Undefined:
  - No FSM or multiplier logic; busy and done tied 0.
  - start is ignored.
  - op 12 behaves as pass A.

Decomposition:
- Shared package alu_pkg:
  - op code constants (OP_ADD..OP_MUL).
  - flag bit indices FLAG_C/Z/N/V.
  - FSM state typedef {IDLE, MUL, DONE}.
- One natural sub-module: alu_mul_seq, the iterative shift-add multiplier. Its interface is start, a, b, busy, product, valid.

Test Plan:
- Reset then load A=0x7F, B=0x01, ADD, flags_write_enable -> bus_out 0x80, flags C=0 Z=0 N=1 V=1.
- A=0x05, B=0x05, SUB -> bus_out 0x00, C=1 Z=1 N=0 V=0. A=0x03, B=0x05, SUB -> 0xFE, C=0 N=1.
- Set C=1 via SHL of 0x80, then A=0x10, B=0x20, ADC -> 0x31. CMP 0x10 vs 0x20 -> bus_out shows 0x10, C=0.
- Both write enables high, bus_in=0xAA -> A=0xAA, B unchanged. No enables -> bus_out 0xFF.
- ALU_MUL_EN: A=0x0F, B=0x11, start with op=12 -> busy 9 cycles, done at cycle 9, A=0xFF, B=0x00, C=0. Then A=0xFF, B=0xFF -> A=0x01, B=0xFE, C=1.
- rst_n pulsed low in the 4th MUL cycle -> busy=0, A=B=0, no done. A write attempted during busy is ignored.
